// File: rtl/pc_fetch_stage.sv
// Instruction-fetch stage: owns the PC, the IF/ID pipeline register and a fetch counter.
// Branch redirects squash the fetched slot; a misaligned redirect target halts fetch until reset.
module pc_fetch_stage #(
  parameter int unsigned PC_W      = 9,
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            Stall,
  input  logic            PcSel,
  input  logic [31:0]     BrPC,
  input  logic [31:0]     InstData,
  output logic [PC_W-1:0] InstAddr,
  output logic [PC_W-1:0] IfId_PC,
  output logic [31:0]     IfId_Instr,
  output logic            IfId_Valid,
  output logic            FlushIdEx,
  output logic            Halted,
  output logic [31:0]     FetchCount
);

  typedef enum logic [0:0] {
    StRun,
    StHalt
  } state_e;

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] ifid_pc_q, ifid_pc_d;
  logic [31:0]     ifid_instr_q, ifid_instr_d;
  logic            ifid_valid_q, ifid_valid_d;
  logic [31:0]     fetch_cnt_q, fetch_cnt_d;

  logic            br_aligned;
  logic [PC_W-1:0] br_target;
  logic [PC_W-1:0] pc_plus4;

  assign br_aligned = (BrPC[1:0] == 2'b00);
  assign br_target  = BrPC[PC_W-1:0];
  assign pc_plus4   = pc_q + PC_W'(4);

  // Target bits above the PC width are architecturally ignored.
  if (PC_W < 32) begin : g_unused_brpc
    logic unused_brpc_hi;
    assign unused_brpc_hi = ^BrPC[31:PC_W];
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_instr_d = ifid_instr_q;
    ifid_valid_d = ifid_valid_q;
    fetch_cnt_d  = fetch_cnt_q;

    case (state_q)
      StRun: begin
        if (PcSel) begin
          // Redirect wins over Stall; the slot behind it becomes a bubble either way.
          ifid_instr_d = NOP_INSTR;
          ifid_valid_d = 1'b0;
          if (br_aligned) begin
            pc_d = br_target;
          end else begin
            state_d = StHalt;
          end
        end else if (!Stall) begin
          ifid_pc_d    = pc_q;
          ifid_instr_d = InstData;
          ifid_valid_d = 1'b1;
          pc_d         = pc_plus4;
          fetch_cnt_d  = fetch_cnt_q + 32'd1;
        end
      end
      StHalt: begin
        ifid_instr_d = NOP_INSTR;
        ifid_valid_d = 1'b0;
      end
      default: begin
        state_d = StRun;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= StRun;
      pc_q         <= '0;
      ifid_pc_q    <= '0;
      ifid_instr_q <= NOP_INSTR;
      ifid_valid_q <= 1'b0;
      fetch_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_valid_q <= ifid_valid_d;
      fetch_cnt_q  <= fetch_cnt_d;
    end
  end

  assign InstAddr   = pc_q;
  assign IfId_PC    = ifid_pc_q;
  assign IfId_Instr = ifid_instr_q;
  assign IfId_Valid = ifid_valid_q;
  assign FetchCount = fetch_cnt_q;
  assign Halted     = (state_q == StHalt);
  assign FlushIdEx  = PcSel && (state_q == StRun);

endmodule

// File: tb/tb_pc_fetch_stage.sv
// Directed bench for pc_fetch_stage: each vector carries hand-computed outputs that a
// negedge monitor pops from a scoreboard queue and compares.
module tb_pc_fetch_stage;

  localparam int unsigned PC_W = 9;
  localparam logic [31:0] NOP  = 32'h00000013;

  logic            clk;
  logic            reset;
  logic            Stall;
  logic            PcSel;
  logic [31:0]     BrPC;
  logic [31:0]     InstData;
  logic [PC_W-1:0] InstAddr;
  logic [PC_W-1:0] IfId_PC;
  logic [31:0]     IfId_Instr;
  logic            IfId_Valid;
  logic            FlushIdEx;
  logic            Halted;
  logic [31:0]     FetchCount;

  pc_fetch_stage #(
    .PC_W     (PC_W),
    .NOP_INSTR(NOP)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .Stall     (Stall),
    .PcSel     (PcSel),
    .BrPC      (BrPC),
    .InstData  (InstData),
    .InstAddr  (InstAddr),
    .IfId_PC   (IfId_PC),
    .IfId_Instr(IfId_Instr),
    .IfId_Valid(IfId_Valid),
    .FlushIdEx (FlushIdEx),
    .Halted    (Halted),
    .FetchCount(FetchCount)
  );

  // Instruction memory stub: word at address a reads as C0DE_0000 | a.
  assign InstData = 32'hC0DE_0000 | {23'b0, InstAddr};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic [31:0] addr;
    logic [31:0] ifid_pc;
    logic [31:0] instr;
    logic        valid;
    logic        flush;
    logic        halted;
    logic [31:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   n_pop = 0;
  int   n_push = 0;

  task automatic check(input int id, input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL vec%0d %s: got %h expected %h", id, name, act, exp);
    end
  endtask

  // Monitor: compare whatever the current cycle is expected to show.
  always @(negedge clk) begin
    if (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      n_pop++;
      check(e.id, "InstAddr",   {23'b0, InstAddr}, e.addr);
      check(e.id, "IfId_PC",    {23'b0, IfId_PC},  e.ifid_pc);
      check(e.id, "IfId_Instr", IfId_Instr,        e.instr);
      check(e.id, "IfId_Valid", {31'b0, IfId_Valid}, {31'b0, e.valid});
      check(e.id, "FlushIdEx",  {31'b0, FlushIdEx},  {31'b0, e.flush});
      check(e.id, "Halted",     {31'b0, Halted},     {31'b0, e.halted});
      check(e.id, "FetchCount", FetchCount,          e.cnt);
    end
  end

  // Apply inputs for this cycle and queue the outputs expected during it.
  task automatic vec(input int id, input logic rst_n, input logic st, input logic sel,
                     input logic [31:0] br, input logic [31:0] addr, input logic [31:0] ipc,
                     input logic [31:0] instr, input logic v, input logic fl, input logic h,
                     input logic [31:0] cnt);
    exp_t e;
    @(posedge clk);
    #1;
    reset = rst_n;
    Stall = st;
    PcSel = sel;
    BrPC  = br;
    e.id = id; e.addr = addr; e.ifid_pc = ipc; e.instr = instr; e.valid = v;
    e.flush = fl; e.halted = h; e.cnt = cnt;
    sb.push_back(e);
    n_push++;
  endtask

  function automatic logic [31:0] im(input logic [31:0] a);
    return 32'hC0DE_0000 | a;
  endfunction

  initial begin
    reset = 1'b0;
    Stall = 1'b0;
    PcSel = 1'b0;
    BrPC  = '0;
    repeat (2) @(posedge clk);
    //   id rst st sel br            addr    ifid_pc instr        v  fl h  cnt
    vec( 0, 0, 0, 0, 32'h0,        32'h000, 32'h000, NOP,          0, 0, 0, 0);
    vec( 1, 1, 0, 0, 32'h0,        32'h000, 32'h000, NOP,          0, 0, 0, 0);
    vec( 2, 1, 0, 0, 32'h0,        32'h004, 32'h000, im(32'h000),  1, 0, 0, 1);
    vec( 3, 1, 0, 0, 32'h0,        32'h008, 32'h004, im(32'h004),  1, 0, 0, 2);
    vec( 4, 1, 1, 0, 32'h0,        32'h00C, 32'h008, im(32'h008),  1, 0, 0, 3);
    vec( 5, 1, 1, 0, 32'h0,        32'h00C, 32'h008, im(32'h008),  1, 0, 0, 3);
    vec( 6, 1, 0, 0, 32'h0,        32'h00C, 32'h008, im(32'h008),  1, 0, 0, 3);
    // Redirect during stall: flush now, bubble next cycle.
    vec( 7, 1, 1, 1, 32'h40,       32'h010, 32'h00C, im(32'h00C),  1, 1, 0, 4);
    vec( 8, 1, 0, 0, 32'h0,        32'h040, 32'h00C, NOP,          0, 0, 0, 4);
    vec( 9, 1, 0, 1, 32'h1FC,      32'h044, 32'h040, im(32'h040),  1, 1, 0, 5);
    vec(10, 1, 0, 0, 32'h0,        32'h1FC, 32'h040, NOP,          0, 0, 0, 5);
    // PC wraps; high target bits ignored.
    vec(11, 1, 0, 1, 32'hFFFFFE00, 32'h000, 32'h1FC, im(32'h1FC),  1, 1, 0, 6);
    vec(12, 1, 0, 1, 32'h42,       32'h000, 32'h1FC, NOP,          0, 1, 0, 6);
    // Halted: redirects and fetches ignored, no flush.
    vec(13, 1, 0, 1, 32'h80,       32'h000, 32'h1FC, NOP,          0, 0, 1, 6);
    vec(14, 1, 0, 0, 32'h0,        32'h000, 32'h1FC, NOP,          0, 0, 1, 6);
    vec(15, 0, 0, 0, 32'h0,        32'h000, 32'h1FC, NOP,          0, 0, 1, 6);
    vec(16, 1, 0, 0, 32'h0,        32'h000, 32'h000, NOP,          0, 0, 0, 0);
    vec(17, 1, 0, 0, 32'h0,        32'h004, 32'h000, im(32'h000),  1, 0, 0, 1);
    // Reset in the same cycle as a redirect.
    vec(18, 0, 0, 1, 32'h40,       32'h008, 32'h004, im(32'h004),  1, 1, 0, 2);
    vec(19, 1, 1, 0, 32'h0,        32'h000, 32'h000, NOP,          0, 0, 0, 0);
    vec(20, 1, 0, 0, 32'h0,        32'h000, 32'h000, NOP,          0, 0, 0, 0);
    vec(21, 1, 0, 0, 32'h0,        32'h004, 32'h000, im(32'h000),  1, 0, 0, 1);
    repeat (3) @(posedge clk);
    n_cmp++;
    if (n_pop != n_push || sb.size() != 0) begin
      n_err++;
      $display("FAIL drain: popped %0d expected %0d", n_pop, n_push);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pc_fetch_stage.md
PC_FETCH_STAGE -- requirements
Module: pc_fetch_stage

Interface
REQ-001 Parameter PC_W, default 9: width of the program counter and instruction-memory address.
REQ-002 Parameter NOP_INSTR, default 32'h00000013: bubble encoding (addi x0,x0,0).
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  synchronous, active-low reset (0 = reset asserted), sampled on rising clk.
REQ-005 Stall  input  1  hazard-unit freeze request for PC and IF/ID.
REQ-006 PcSel  input  1  redirect request from the branch unit (1 = taken branch/jal/jalr).
REQ-007 BrPC  input  32  redirect target, valid when PcSel=1.
REQ-008 InstData  input  32  instruction-memory read data, combinational from InstAddr in the same cycle.
REQ-009 InstAddr  output  PC_W  current PC driven to instruction memory.
REQ-010 IfId_PC  output  PC_W  registered PC of the instruction in IF/ID.
REQ-011 IfId_Instr  output  32  registered instruction in IF/ID.
REQ-012 IfId_Valid  output  1  registered; 1 = IF/ID holds a real instruction.
REQ-013 FlushIdEx  output  1  combinational; 1 = downstream SHALL squash ID/EX this cycle.
REQ-014 Halted  output  1  registered; 1 = stage is in HALT.
REQ-015 FetchCount  output  32  registered count of instructions accepted into IF/ID.

Function
REQ-016 State machine SHALL have two states: RUN and HALT.
REQ-017 InstAddr SHALL equal the PC register at all times.
REQ-018 RUN, PcSel=1, BrPC[1:0]=2'b00: PC <= BrPC[PC_W-1:0], IF/ID <= {PC unchanged, NOP_INSTR, Valid 0}, FetchCount unchanged.
REQ-019 RUN, PcSel=1, BrPC[1:0]!=2'b00: state <= HALT, PC unchanged, IF/ID Valid <= 0, IF/ID Instr <= NOP_INSTR.
REQ-020 RUN, PcSel=0, Stall=1: PC, IF/ID and FetchCount SHALL hold their values.
REQ-021 RUN, PcSel=0, Stall=0: IF/ID <= {PC, InstData, 1}, PC <= PC+4, FetchCount <= FetchCount+1.
REQ-022 PcSel SHALL take priority over Stall; a redirect in a stalled cycle SHALL be applied.
REQ-023 FlushIdEx SHALL equal PcSel AND (state==RUN), independent of Stall.
REQ-024 PC+4 SHALL wrap modulo 2^PC_W; BrPC bits above PC_W-1 SHALL be ignored.
REQ-025 FetchCount SHALL wrap from 32'hFFFFFFFF to 0.
REQ-026 HALT: PC and FetchCount hold, IF/ID Valid=0, Instr=NOP_INSTR, FlushIdEx=0; PcSel and Stall ignored; exit only by reset.
REQ-027 Halted SHALL be 1 exactly when state==HALT.

Reset
REQ-028 reset=0 at a rising edge SHALL override all inputs and set: state RUN, PC 0, IfId_PC 0, IfId_Instr NOP_INSTR, IfId_Valid 0, Halted 0, FetchCount 0.
REQ-029 Reset asserted mid-stall, mid-redirect or in HALT SHALL produce the REQ-028 values on the next edge, with no carry-over of pending state.
REQ-030 First fetch after deassertion SHALL be from address 0.

Verification
REQ-031 Release reset, InstData=A,B,C from addresses 0,4,8, no stall -> IfId_PC 0,4,8 on successive cycles, Valid=1, FetchCount=3.
REQ-032 Stall=1 for 2 cycles at PC=8 -> InstAddr stays 8, IF/ID holds PC 4, FetchCount frozen, resumes at 8 when Stall drops.
REQ-033 PcSel=1, BrPC=0x40 with Stall=1 -> FlushIdEx=1 that cycle, next cycle InstAddr=0x40, IfId_Valid=0, IfId_Instr=0x00000013.
REQ-034 PcSel=1, BrPC=0x42 -> Halted=1 next cycle, InstAddr frozen, IfId_Valid=0; later PcSel pulses ignored; reset=0 restores PC 0, Halted 0.
REQ-035 PC=0x1FC (PC_W=9), no stall -> next InstAddr=0x000; BrPC=0xFFFFFE00 -> InstAddr=0x000.
REQ-036 reset=0 asserted the same cycle as PcSel=1 -> next cycle PC 0, Valid 0, FetchCount 0, Halted 0.
